reg_bus_arbiter: RTL and testbench
==================================

// Module: reg_bus_arbiter
// PURPOSE
//   Shares the single register-file access bus (read/write/addr/wdata/rdata) between the SPI
//   instruction decoder (port S: one-cycle strobes, no backpressure) and an internal hardware
//   master (port H: req/ack handshake, e.g. PWM period reload sequencer). Port S has priority.
//   S strobes that collide with an H access are held in a one-entry pending slot. S read data
//   comes from a read-ahead snapshot, so the decoder never waits.
// PARAMETERS
//   AW   6   register address width
//   DW   8   register data width
// PORTS
//   clk      in   1   single clock; one clock clk, reset rst is asynchronous and active-high
//   rst      in   1   asynchronous, active-high reset
//   s_read   in   1   decoder read strobe, 1-cycle pulse
//   s_write  in   1   decoder write strobe, 1-cycle pulse
//   s_addr   in   AW  decoder target address (stable across a byte)
//   s_wdata  in   DW  decoder write data, valid with s_write
//   s_rdata  out  DW  read-ahead snapshot of register at s_addr (decoder's data_read)
//   s_ovf    out  1   sticky: S strobe arrived while pending slot full
//   h_req    in   1   H request; held high until h_ack
//   h_we     in   1   H op: 1=write, 0=read; stable while h_req
//   h_addr   in   AW  H address; stable while h_req
//   h_wdata  in   DW  H write data; stable while h_req
//   h_ack    out  1   1-cycle pulse: H op done
//   h_rdata  out  DW  H read data, valid with h_ack, held until next h_ack
//   reg_read  out 1   register-file read strobe (side effects, e.g. clear-on-read)
//   reg_write out 1   register-file write strobe
//   reg_addr  out AW  register-file address
//   reg_wdata out DW  register-file write data
//   reg_rdata in  DW  register-file combinational read data for reg_addr
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, pending slot empty, s_ovf=0. All outputs registered.
//   Pending slot {valid, op(rd/wr), addr, wdata}: loads on s_read|s_write; s_write wins if both.
//     Strobe while valid and not draining that cycle -> overwrite slot, set s_ovf (cleared only by rst).
//   FSM: IDLE, S_ACC, H_ACC, H_ACK.
//     IDLE: slot valid or new S strobe -> S_ACC, issue S op next cycle (reg_* from slot or
//       direct strobe, slot drains). Else h_req -> H_ACC, issue H op. Else reg_addr<=s_addr.
//     S_ACC: strobe high 1 cycle -> IDLE.  H_ACC: strobe high 1 cycle, addr held -> H_ACK.
//     H_ACK: reg_addr held; h_rdata<=reg_rdata (reads), h_ack=1 -> IDLE.
//   Latency: S strobe at edge N -> reg strobe in cycle N+1 if IDLE; worst case N+3 (H in flight).
//     H: h_req seen in IDLE at edge N -> reg strobe N+1, h_ack N+2.
//   Tie S vs h_req in IDLE: S wins; H served next IDLE cycle without S work (no starvation:
//     S strobes are >=8 SCK apart).
//   s_rdata <= reg_rdata each cycle in IDLE when reg_addr==s_addr; frozen in S_ACC/H_ACC/H_ACK.
//   h_req dropped before h_ack: protocol violation; op still completes, h_ack still pulses.
//   Reset mid-op: op aborted, slot lost, no h_ack; address arithmetic none (no wrap).
// STRUCTURE
//   Package reg_bus_pkg: AW/DW defaults, state enum arb_state_t, op enum {OP_RD, OP_WR},
//     typedef struct pend_t {valid, op, addr, wdata}.
//   One sub-module: reg_pend_slot (load/drain/overflow logic of the pending entry).
//   Top holds FSM, output registers, snapshot register.
// TESTING
//   1 idle, s_write addr=0x05 data=0xA5 -> reg_write=1 addr=0x05 wdata=0xA5 next cycle, 1 cycle wide.
//   2 h_req read addr=0x10, reg_rdata=0x3C -> reg_read 1 cycle, h_ack + h_rdata=0x3C one cycle later.
//   3 s_write 0x02/0x11 same cycle as h_req write 0x03/0x22 -> S write issued first, then H; h_ack once.
//   4 s_write during H_ACC -> slot holds it, reg_write addr/data issued 2 cycles later; s_ovf stays 0.
//   5 two s_write while H in flight -> second overwrites slot, s_ovf=1 sticky; only second reaches regs.
//   6 s_addr=0x07, reg[7]=0x5A idle -> s_rdata=0x5A within 2 cycles; rst mid H_ACC -> all outputs 0, no h_ack.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared types and widths for the register-bus arbiter.
package reg_bus_pkg;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSAcc = 2'd1,
        StHAcc = 2'd2,
        StHAck = 2'd3
    } arb_state_t;

    typedef enum logic {
        OpRd = 1'b0,
        OpWr = 1'b1
    } op_t;

    typedef struct packed {
        logic          valid;
        op_t           op;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } pend_t;

endpackage

// File: rtl/reg_pend_slot.sv
// One-entry holding slot for decoder strobes that cannot be issued right away.
module reg_pend_slot
    import reg_bus_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_s_read,
    input  logic          i_s_write,
    input  logic [AW-1:0] i_s_addr,
    input  logic [DW-1:0] i_s_wdata,
    input  logic          i_drain,   // slot content is issued on the bus this cycle
    input  logic          i_bypass,  // new strobe is issued directly, do not capture it
    output logic          o_valid,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_wdata,
    output logic          o_ovf
);

    pend_t r_pend;
    logic  r_ovf;
    logic  w_load;

    assign w_load = (i_s_read | i_s_write) & ~i_bypass;

    // Capture/overwrite on a strobe, clear on drain; overflow is sticky until reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_load) begin
                r_pend.valid <= 1'b1;
                r_pend.op    <= i_s_write ? OpWr : OpRd;
                r_pend.addr  <= i_s_addr;
                r_pend.wdata <= i_s_wdata;
            end else if (i_drain) begin
                r_pend.valid <= 1'b0;
            end
            if (w_load && r_pend.valid && !i_drain) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_valid = r_pend.valid;
    assign o_we    = (r_pend.op == OpWr);
    assign o_addr  = r_pend.addr;
    assign o_wdata = r_pend.wdata;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/reg_bus_arbiter.sv
// Arbitrates the register-file bus between the SPI decoder (S, priority) and a
// handshaked hardware master (H). All outputs are registered.
module reg_bus_arbiter
    import reg_bus_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_s_read,
    input  logic          i_s_write,
    input  logic [AW-1:0] i_s_addr,
    input  logic [DW-1:0] i_s_wdata,
    output logic [DW-1:0] o_s_rdata,
    output logic          o_s_ovf,
    input  logic          i_h_req,
    input  logic          i_h_we,
    input  logic [AW-1:0] i_h_addr,
    input  logic [DW-1:0] i_h_wdata,
    output logic          o_h_ack,
    output logic [DW-1:0] o_h_rdata,
    output logic          o_reg_read,
    output logic          o_reg_write,
    output logic [AW-1:0] o_reg_addr,
    output logic [DW-1:0] o_reg_wdata,
    input  logic [DW-1:0] i_reg_rdata
);

    arb_state_t    r_state;
    arb_state_t    w_state_next;

    logic          r_reg_read;
    logic          r_reg_write;
    logic [AW-1:0] r_reg_addr;
    logic [DW-1:0] r_reg_wdata;
    logic          r_h_ack;
    logic [DW-1:0] r_h_rdata;
    logic [DW-1:0] r_s_rdata;

    logic          w_reg_read_d;
    logic          w_reg_write_d;
    logic [AW-1:0] w_reg_addr_d;
    logic [DW-1:0] w_reg_wdata_d;
    logic          w_h_ack_d;
    logic [DW-1:0] w_h_rdata_d;
    logic [DW-1:0] w_s_rdata_d;

    logic          w_s_strobe;
    logic          w_idle;
    logic          w_drain;
    logic          w_bypass;
    logic          w_pend_valid;
    logic          w_pend_we;
    logic [AW-1:0] w_pend_addr;
    logic [DW-1:0] w_pend_wdata;

    assign w_s_strobe = i_s_read | i_s_write;
    assign w_idle     = (r_state == StIdle);
    // In IDLE a held entry goes out first; a fresh strobe only bypasses an empty slot.
    assign w_drain    = w_idle & w_pend_valid;
    assign w_bypass   = w_idle & ~w_pend_valid;

    reg_pend_slot u_slot (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_s_read  (i_s_read),
        .i_s_write (i_s_write),
        .i_s_addr  (i_s_addr),
        .i_s_wdata (i_s_wdata),
        .i_drain   (w_drain),
        .i_bypass  (w_bypass),
        .o_valid   (w_pend_valid),
        .o_we      (w_pend_we),
        .o_addr    (w_pend_addr),
        .o_wdata   (w_pend_wdata),
        .o_ovf     (o_s_ovf)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: S work beats H, every access is a fixed-length sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_pend_valid || w_s_strobe) begin
                    w_state_next = StSAcc;
                end else if (i_h_req) begin
                    w_state_next = StHAcc;
                end
            end
            StSAcc:  w_state_next = StIdle;
            StHAcc:  w_state_next = StHAck;
            StHAck:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Output next values: bus strobes last one cycle, address/data hold otherwise.
    always_comb begin
        w_reg_read_d  = 1'b0;
        w_reg_write_d = 1'b0;
        w_reg_addr_d  = r_reg_addr;
        w_reg_wdata_d = r_reg_wdata;
        w_h_ack_d     = 1'b0;
        w_h_rdata_d   = r_h_rdata;
        w_s_rdata_d   = r_s_rdata;
        case (r_state)
            StIdle: begin
                // Read-ahead: refresh the snapshot only when the bus points at s_addr.
                if (r_reg_addr == i_s_addr) begin
                    w_s_rdata_d = i_reg_rdata;
                end
                if (w_pend_valid) begin
                    w_reg_write_d = w_pend_we;
                    w_reg_read_d  = ~w_pend_we;
                    w_reg_addr_d  = w_pend_addr;
                    w_reg_wdata_d = w_pend_wdata;
                end else if (w_s_strobe) begin
                    w_reg_write_d = i_s_write;
                    w_reg_read_d  = i_s_read & ~i_s_write;
                    w_reg_addr_d  = i_s_addr;
                    w_reg_wdata_d = i_s_wdata;
                end else if (i_h_req) begin
                    w_reg_write_d = i_h_we;
                    w_reg_read_d  = ~i_h_we;
                    w_reg_addr_d  = i_h_addr;
                    w_reg_wdata_d = i_h_wdata;
                end else begin
                    w_reg_addr_d = i_s_addr;
                end
            end
            StHAcc: begin
                // reg_rdata is valid for the H address during the strobe cycle.
                w_h_ack_d = 1'b1;
                if (r_reg_read) begin
                    w_h_rdata_d = i_reg_rdata;
                end
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_reg_read  <= 1'b0;
            r_reg_write <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_h_ack     <= 1'b0;
            r_h_rdata   <= '0;
            r_s_rdata   <= '0;
        end else begin
            r_reg_read  <= w_reg_read_d;
            r_reg_write <= w_reg_write_d;
            r_reg_addr  <= w_reg_addr_d;
            r_reg_wdata <= w_reg_wdata_d;
            r_h_ack     <= w_h_ack_d;
            r_h_rdata   <= w_h_rdata_d;
            r_s_rdata   <= w_s_rdata_d;
        end
    end

    assign o_reg_read  = r_reg_read;
    assign o_reg_write = r_reg_write;
    assign o_reg_addr  = r_reg_addr;
    assign o_reg_wdata = r_reg_wdata;
    assign o_h_ack     = r_h_ack;
    assign o_h_rdata   = r_h_rdata;
    assign o_s_rdata   = r_s_rdata;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed scenarios plus a randomized run scored
// against ordering/latency rules and a bench-owned register file.
module tb_reg_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_read, s_write, h_req, h_we;
    logic [5:0] s_addr, h_addr;
    logic [7:0] s_wdata, h_wdata;
    logic [7:0] s_rdata, h_rdata, reg_wdata, reg_rdata;
    logic       s_ovf, h_ack, reg_read, reg_write;
    logic [5:0] reg_addr;

    logic [7:0] regs [64];
    logic       bd_we = 1'b0;
    logic [5:0] bd_addr = '0;
    logic [7:0] bd_data = '0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit         we;
        logic [5:0] addr;
        logic [7:0] wdata;
        int         at;
    } sop_t;
    sop_t sq[$];

    always #5 clk = ~clk;

    reg_bus_arbiter dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_s_read    (s_read),
        .i_s_write   (s_write),
        .i_s_addr    (s_addr),
        .i_s_wdata   (s_wdata),
        .o_s_rdata   (s_rdata),
        .o_s_ovf     (s_ovf),
        .i_h_req     (h_req),
        .i_h_we      (h_we),
        .i_h_addr    (h_addr),
        .i_h_wdata   (h_wdata),
        .o_h_ack     (h_ack),
        .o_h_rdata   (h_rdata),
        .o_reg_read  (reg_read),
        .o_reg_write (reg_write),
        .o_reg_addr  (reg_addr),
        .o_reg_wdata (reg_wdata),
        .i_reg_rdata (reg_rdata)
    );

    // Environment register file: combinational read, write on the bus strobe.
    assign reg_rdata = regs[reg_addr];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) regs[i] <= 8'(i * 37 + 11);
        end else if (bd_we) begin
            regs[bd_addr] <= bd_data;
        end else if (reg_write) begin
            regs[reg_addr] <= reg_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_read = 0; s_write = 0; s_addr = '0; s_wdata = '0;
        h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        step();
    endtask

    task automatic poke(input logic [5:0] a, input logic [7:0] d);
        bd_we = 1; bd_addr = a; bd_data = d;
        step();
        bd_we = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        step();
        n_vec++;
        if ({reg_read, reg_write, reg_addr, reg_wdata, h_ack, h_rdata, s_rdata, s_ovf} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h wd=%h ack=%b hrd=%h srd=%h ovf=%b, want all 0",
                     reg_read, reg_write, reg_addr, reg_wdata, h_ack, h_rdata, s_rdata, s_ovf);
        end
        rst = 0;
        step();
    endtask

    task automatic test_s_write();
        do_reset();
        s_write = 1; s_addr = 6'h05; s_wdata = 8'hA5;
        step();
        s_write = 0;
        n_vec++;
        if (reg_write !== 1 || reg_read !== 0 || reg_addr !== 6'h05 || reg_wdata !== 8'hA5) begin
            n_err++;
            $display("FAIL s_write_issue: got wr=%b rd=%b addr=%h wd=%h, want wr=1 rd=0 addr=05 wd=a5",
                     reg_write, reg_read, reg_addr, reg_wdata);
        end
        step();
        n_vec++;
        if (reg_write !== 0) begin
            n_err++;
            $display("FAIL s_write_width: got wr=%b, want 0", reg_write);
        end
    endtask

    task automatic test_h_read();
        do_reset();
        poke(6'h10, 8'h3C);
        h_req = 1; h_we = 0; h_addr = 6'h10;
        step();
        n_vec++;
        if (reg_read !== 1 || reg_addr !== 6'h10 || h_ack !== 0) begin
            n_err++;
            $display("FAIL h_read_issue: got rd=%b addr=%h ack=%b, want rd=1 addr=10 ack=0",
                     reg_read, reg_addr, h_ack);
        end
        step();
        n_vec++;
        if (reg_read !== 0 || h_ack !== 1 || h_rdata !== 8'h3C) begin
            n_err++;
            $display("FAIL h_read_ack: got rd=%b ack=%b hrd=%h, want rd=0 ack=1 hrd=3c",
                     reg_read, h_ack, h_rdata);
        end
        h_req = 0;
        step();
        n_vec++;
        if (h_ack !== 0 || h_rdata !== 8'h3C) begin
            n_err++;
            $display("FAIL h_read_hold: got ack=%b hrd=%h, want ack=0 hrd=3c", h_ack, h_rdata);
        end
    endtask

    task automatic test_tie();
        int acks = 0;
        do_reset();
        s_write = 1; s_addr = 6'h02; s_wdata = 8'h11;
        h_req = 1; h_we = 1; h_addr = 6'h03; h_wdata = 8'h22;
        step();
        s_write = 0;
        n_vec++;
        if (reg_write !== 1 || reg_addr !== 6'h02 || reg_wdata !== 8'h11) begin
            n_err++;
            $display("FAIL tie_s_first: got wr=%b addr=%h wd=%h, want wr=1 addr=02 wd=11",
                     reg_write, reg_addr, reg_wdata);
        end
        step();
        step();
        n_vec++;
        if (reg_write !== 1 || reg_addr !== 6'h03 || reg_wdata !== 8'h22) begin
            n_err++;
            $display("FAIL tie_h_second: got wr=%b addr=%h wd=%h, want wr=1 addr=03 wd=22",
                     reg_write, reg_addr, reg_wdata);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (h_ack === 1) begin
                acks++;
                h_req = 0;
            end
        end
        n_vec++;
        if (acks != 1) begin
            n_err++;
            $display("FAIL tie_ack_count: got %0d acks, want 1", acks);
        end
    endtask

    task automatic test_slot();
        do_reset();
        h_req = 1; h_we = 1; h_addr = 6'h20; h_wdata = 8'h77;
        step();
        s_write = 1; s_addr = 6'h08; s_wdata = 8'h99;
        step();
        s_write = 0;
        h_req = 0;
        step();
        n_vec++;
        if (reg_write !== 0) begin
            n_err++;
            $display("FAIL slot_wait: got wr=%b, want 0", reg_write);
        end
        step();
        n_vec++;
        if (reg_write !== 1 || reg_addr !== 6'h08 || reg_wdata !== 8'h99 || s_ovf !== 0) begin
            n_err++;
            $display("FAIL slot_issue: got wr=%b addr=%h wd=%h ovf=%b, want wr=1 addr=08 wd=99 ovf=0",
                     reg_write, reg_addr, reg_wdata, s_ovf);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] old9;
        do_reset();
        old9 = regs[9];
        h_req = 1; h_we = 1; h_addr = 6'h21; h_wdata = 8'h44;
        step();
        s_write = 1; s_addr = 6'h09; s_wdata = 8'h01;
        step();
        s_addr = 6'h0A; s_wdata = 8'h02;
        h_req = 0;
        step();
        s_write = 0;
        n_vec++;
        if (s_ovf !== 1) begin
            n_err++;
            $display("FAIL ovf_set: got ovf=%b, want 1", s_ovf);
        end
        step();
        n_vec++;
        if (reg_write !== 1 || reg_addr !== 6'h0A || reg_wdata !== 8'h02) begin
            n_err++;
            $display("FAIL ovf_second_wins: got wr=%b addr=%h wd=%h, want wr=1 addr=0a wd=02",
                     reg_write, reg_addr, reg_wdata);
        end
        for (int i = 0; i < 4; i++) step();
        n_vec++;
        if (s_ovf !== 1 || regs[9] !== old9 || regs[10] !== 8'h02) begin
            n_err++;
            $display("FAIL ovf_sticky: got ovf=%b reg9=%h reg10=%h, want ovf=1 reg9=%h reg10=02",
                     s_ovf, regs[9], regs[10], old9);
        end
    endtask

    task automatic test_snapshot_and_abort();
        int acks = 0;
        do_reset();
        poke(6'h07, 8'h5A);
        s_addr = 6'h07;
        step();
        step();
        n_vec++;
        if (s_rdata !== 8'h5A) begin
            n_err++;
            $display("FAIL snapshot: got s_rdata=%h, want 5a", s_rdata);
        end
        h_req = 1; h_we = 0; h_addr = 6'h10;
        step();
        rst = 1;
        h_req = 0;
        #1;
        n_vec++;
        if ({reg_read, reg_write, reg_addr, reg_wdata, h_ack, h_rdata, s_rdata, s_ovf} !== '0) begin
            n_err++;
            $display("FAIL abort_outputs: got rd=%b wr=%b addr=%h wd=%h ack=%b hrd=%h srd=%h ovf=%b, want all 0",
                     reg_read, reg_write, reg_addr, reg_wdata, h_ack, h_rdata, s_rdata, s_ovf);
        end
        step();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (h_ack === 1) acks++;
        end
        n_vec++;
        if (acks != 0) begin
            n_err++;
            $display("FAIL abort_no_ack: got %0d acks, want 0", acks);
        end
    endtask

    // Randomized run: S ops must reach the bus in order within two edges of their
    // strobe; H ops only when no S op is outstanding, acked one edge after issue.
    task automatic test_random(input int ncyc);
        int         cyc = 0;
        int         s_gap = 2;
        int         h_gap = 1;
        bit         h_active = 0;
        bit         h_issued = 0;
        int         h_start = 0;
        int         h_issue_at = 0;
        logic [7:0] h_exp = '0;
        sop_t       op;
        do_reset();
        sq.delete();
        while (cyc < ncyc) begin
            step();
            cyc++;
            // Observe the bus.
            if (reg_read === 1 && reg_write === 1) begin
                n_vec++; n_err++;
                $display("FAIL rnd_both_strobes: cyc=%0d got rd=1 wr=1, want at most one", cyc);
            end else if (reg_read === 1 || reg_write === 1) begin
                n_vec++;
                if (sq.size() > 0) begin
                    if (reg_write !== sq[0].we || reg_addr !== sq[0].addr ||
                        (sq[0].we && reg_wdata !== sq[0].wdata)) begin
                        n_err++;
                        $display("FAIL rnd_s_op: cyc=%0d got wr=%b addr=%h wd=%h, want wr=%b addr=%h wd=%h",
                                 cyc, reg_write, reg_addr, reg_wdata, sq[0].we, sq[0].addr, sq[0].wdata);
                    end
                    void'(sq.pop_front());
                end else if (!h_active || h_issued || reg_write !== h_we || reg_addr !== h_addr ||
                             (h_we && reg_wdata !== h_wdata)) begin
                    n_err++;
                    $display("FAIL rnd_h_op: cyc=%0d got wr=%b addr=%h wd=%h, want wr=%b addr=%h (active=%0d issued=%0d)",
                             cyc, reg_write, reg_addr, reg_wdata, h_we, h_addr, h_active, h_issued);
                end else begin
                    h_issued = 1;
                    h_issue_at = cyc;
                    h_exp = regs[h_addr];
                end
            end
            if (sq.size() > 0 && cyc >= sq[0].at + 2) begin
                n_vec++; n_err++;
                $display("FAIL rnd_s_latency: cyc=%0d op at %h strobed at %0d not issued", cyc,
                         sq[0].addr, sq[0].at);
                void'(sq.pop_front());
            end
            if (h_ack === 1) begin
                n_vec++;
                if (!h_active || !h_issued || cyc != h_issue_at + 1) begin
                    n_err++;
                    $display("FAIL rnd_h_ack: cyc=%0d got ack, want ack at %0d (active=%0d issued=%0d)",
                             cyc, h_issue_at + 1, h_active, h_issued);
                end else if (!h_we) begin
                    n_vec++;
                    if (h_rdata !== h_exp) begin
                        n_err++;
                        $display("FAIL rnd_h_rdata: cyc=%0d got %h, want %h", cyc, h_rdata, h_exp);
                    end
                end
                h_req = 0;
                h_active = 0;
                h_gap = $urandom_range(1, 6);
            end else if (h_active && cyc > h_start + 10) begin
                n_vec++; n_err++;
                $display("FAIL rnd_h_timeout: cyc=%0d request from %0d not acked", cyc, h_start);
                h_req = 0;
                h_active = 0;
                h_gap = 2;
            end
            // Drive the next edge.
            s_read = 0;
            s_write = 0;
            if (s_gap == 0 && cyc < ncyc - 20) begin
                op.we = ($urandom_range(0, 1) == 1);
                s_write = op.we;
                s_read = !op.we || ($urandom_range(0, 3) == 0);
                op.addr = 6'($urandom);
                op.wdata = 8'($urandom);
                op.at = cyc + 1;
                s_addr = op.addr;
                s_wdata = op.wdata;
                sq.push_back(op);
                s_gap = $urandom_range(4, 12);
            end else if (s_gap > 0) begin
                s_gap--;
            end
            if (!h_active && cyc < ncyc - 20) begin
                if (h_gap == 0) begin
                    h_req = 1;
                    h_we = ($urandom_range(0, 1) == 1);
                    h_addr = 6'($urandom);
                    h_wdata = 8'($urandom);
                    h_active = 1;
                    h_issued = 0;
                    h_start = cyc + 1;
                end else begin
                    h_gap--;
                end
            end
        end
        n_vec++;
        if (sq.size() != 0 || h_active || s_ovf !== 0) begin
            n_err++;
            $display("FAIL rnd_end: got pending_s=%0d h_active=%0d ovf=%b, want 0 0 0",
                     sq.size(), h_active, s_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_s_write();
        test_h_read();
        test_tie();
        test_slot();
        test_overflow();
        test_snapshot_and_abort();
        test_random(3000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
